binarization_input_stream: RTL and testbench

Streaming, parametrised successor to the combinational input binarizer. Accepts one kernel window of KERNEL_SIZE pixels per input beat. Converts each pixel to a CHANNEL_CNT-wide thermometer code in signed or unsigned mode. Emits the code serially in GROUP_CH-channel slices over a valid/ready interface to the first binary conv layer, which consumes a narrower channel slice per cycle.

---
 rtl/binarize_pkg.sv | 36 +++
 rtl/binarize_thermo_slice.sv | 21 ++
 rtl/binarization_input_stream.sv | 164 ++++++++++++++++
 tb/tb_binarization_input_stream.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/binarize_pkg.sv
// Shared definitions for the streaming thermometer binarizer: FSM state codes,
// derived-width helpers and the per-pixel ones-count conversion.
package binarize_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  typedef logic [0:0] state_t;

  function automatic int calc_num_groups(input int channels, input int group_ch);
    return channels / group_ch;
  endfunction

  function automatic int calc_group_w(input int num_groups);
    return (num_groups > 1) ? $clog2(num_groups) : 1;
  endfunction

  function automatic int calc_count_w(input int bit_width);
    return bit_width + 1;
  endfunction

  // Adding half the range to a sign-extended two's-complement value is the
  // same as inverting its MSB (offset-binary), so no adder is needed.
  function automatic logic [31:0] ones_count(input logic [31:0] pixel,
                                             input int bit_width,
                                             input logic is_signed);
    logic [31:0] mask_s;
    mask_s = (32'd1 << bit_width) - 32'd1;
    if (is_signed) begin
      ones_count = (pixel & mask_s) ^ (32'd1 << (bit_width - 1));
    end else begin
      ones_count = pixel & mask_s;
    end
  endfunction

endpackage

// File: rtl/binarize_thermo_slice.sv
// One GROUP_CH-wide window of a pixel's thermometer code: bit j is set when
// channel (group*GROUP_CH + j) lies below the pixel's ones count.
module binarize_thermo_slice #(
  parameter int GROUP_CH = 64,
  parameter int COUNT_W  = 9,
  parameter int GROUP_W  = 2
) (
  input  logic [COUNT_W-1:0]  ones_i,
  input  logic [GROUP_W-1:0]  group_i,
  output logic [GROUP_CH-1:0] slice_o
);

  // Per-channel compare against the ones count.
  always_comb begin
    slice_o = {GROUP_CH{1'b0}};
    for (int j = 0; j < GROUP_CH; j++) begin
      slice_o[j] = ((32'(group_i) * 32'(GROUP_CH)) + 32'(j)) < 32'(ones_i);
    end
  end

endmodule

// File: rtl/binarization_input_stream.sv
// Streaming input binarizer: latches one kernel window per accept and emits its
// thermometer code in GROUP_CH-channel slices. Define BINARIZE_ZSKIP_EN to drop
// all-zero trailing slices.
module binarization_input_stream
  import binarize_pkg::*;
#(
  parameter int KERNEL_SIZE = 9,
  parameter int BIT_WIDTH   = 8,
  parameter int CHANNEL_CNT = 256,
  parameter int GROUP_CH    = 64
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              mode_signed,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [KERNEL_SIZE*BIT_WIDTH-1:0]                  in_pixel,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [KERNEL_SIZE*GROUP_CH-1:0]                   out_data,
  output logic [calc_group_w(CHANNEL_CNT/GROUP_CH)-1:0]     out_group,
  output logic                                              out_last
);

  localparam int NUM_GROUPS = calc_num_groups(CHANNEL_CNT, GROUP_CH);
  localparam int GW         = calc_group_w(NUM_GROUPS);
  localparam int CW         = calc_count_w(BIT_WIDTH);
  localparam int DW         = KERNEL_SIZE * GROUP_CH;
  localparam logic [GW-1:0] LAST_FULL = GW'(NUM_GROUPS - 1);

  state_t                          state_q, state_d;
  logic [GW-1:0]                   group_q, group_d;
  logic [GW-1:0]                   last_group_q, last_group_d;
  logic [KERNEL_SIZE-1:0][CW-1:0]  ones_q, ones_d;
  logic                            valid_q, valid_d;
  logic                            last_q, last_d;
  logic [DW-1:0]                   data_q, data_d;

  logic [KERNEL_SIZE-1:0][CW-1:0]  new_ones_s;
  logic [GW-1:0]                   new_last_s;
  logic [DW-1:0]                   slice_s;

  // Convert every incoming pixel to its ones count using the current mode.
  always_comb begin
    new_ones_s = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      new_ones_s[k] = CW'(ones_count(32'(in_pixel[k*BIT_WIDTH +: BIT_WIDTH]),
                                     BIT_WIDTH, mode_signed));
    end
  end

`ifdef BINARIZE_ZSKIP_EN
  // Highest slice holding any set bit across the window; group 0 always emitted.
  always_comb begin
    int need_s;
    int top_s;
    top_s = 1;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      need_s = (int'(new_ones_s[k]) + GROUP_CH - 1) / GROUP_CH;
      if (need_s > top_s) begin
        top_s = need_s;
      end else begin
        top_s = top_s;
      end
    end
    new_last_s = GW'(top_s - 1);
  end
`else
  assign new_last_s = LAST_FULL;
`endif

  assign in_ready = (state_q == IDLE) || (valid_q && out_ready && last_q);

  // Window sequencing; a final-slice fire may accept the next beat directly.
  always_comb begin
    state_d      = state_q;
    group_d      = group_q;
    last_group_d = last_group_q;
    ones_d       = ones_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d      = EMIT;
          group_d      = {GW{1'b0}};
          ones_d       = new_ones_s;
          last_group_d = new_last_s;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!last_q) begin
            group_d = group_q + GW'(1);
          end else if (in_valid) begin
            group_d      = {GW{1'b0}};
            ones_d       = new_ones_s;
            last_group_d = new_last_s;
          end else begin
            state_d = IDLE;
            group_d = {GW{1'b0}};
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
        group_d = {GW{1'b0}};
      end
    endcase
  end

  for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_slice
    binarize_thermo_slice #(
      .GROUP_CH (GROUP_CH),
      .COUNT_W  (CW),
      .GROUP_W  (GW)
    ) u_slice (
      .ones_i  (ones_d[k]),
      .group_i (group_d),
      .slice_o (slice_s[k*GROUP_CH +: GROUP_CH])
    );
  end

  // Outputs are precomputed from next state so they come straight from flops.
  always_comb begin
    valid_d = (state_d == EMIT);
    if (valid_d) begin
      last_d = (group_d == last_group_d);
      data_d = slice_s;
    end else begin
      last_d = 1'b0;
      data_d = {DW{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      group_q      <= {GW{1'b0}};
      last_group_q <= {GW{1'b0}};
      ones_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      data_q       <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      group_q      <= group_d;
      last_group_q <= last_group_d;
      ones_q       <= ones_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      data_q       <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_group = group_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_binarization_input_stream.sv
// Directed bench for binarization_input_stream (default 9x8-bit, 256 ch, 64/beat);
// beat counts follow BINARIZE_ZSKIP_EN when it is defined.
module tb_binarization_input_stream;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZERO = 64'h0;

  logic         clk;
  logic         rst_n;
  logic         mode_signed;
  logic         in_valid;
  logic         in_ready;
  logic [71:0]  in_pixel;
  logic         out_valid;
  logic         out_ready;
  logic [575:0] out_data;
  logic [1:0]   out_group;
  logic         out_last;

  int n_vec;
  int n_err;

  binarization_input_stream dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_signed (mode_signed),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_group   (out_group),
    .out_last    (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkg(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one window, flip mode afterwards (must be ignored), check each slice.
  task automatic run_window(input string tag, input logic [71:0] pix, input logic sgn,
                            input int beats, input logic [575:0] e0, input logic [575:0] e1,
                            input logic [575:0] e2, input logic [575:0] e3);
    logic [575:0] exp_d;
    in_pixel    = pix;
    mode_signed = sgn;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    step();
    in_valid    = 1'b0;
    mode_signed = ~sgn;
    for (int g = 0; g < beats; g++) begin
      exp_d = (g == 0) ? e0 : (g == 1) ? e1 : (g == 2) ? e2 : e3;
      chk1({tag, "_valid"}, out_valid, 1'b1);
      chkg({tag, "_group"}, out_group, 2'(g));
      chk1({tag, "_last"}, out_last, (g == beats - 1));
      chkd({tag, "_data"}, out_data, exp_d);
      step();
    end
    chk1({tag, "_idle_valid"}, out_valid, 1'b0);
    chk1({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int b_zero;
    int b_min;
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    mode_signed = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_pixel    = 72'h0;
`ifdef BINARIZE_ZSKIP_EN
    b_zero = 2;
    b_min  = 1;
`else
    b_zero = 4;
    b_min  = 4;
`endif

    // 1: reset state, then idle with in_valid low
    #3;
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_ready", in_ready, 1'b1);
    chkg("rst_group", out_group, 2'd0);
    chk1("rst_last", out_last, 1'b0);
    chkd("rst_data", out_data, 576'h0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk1("idle_valid", out_valid, 1'b0);
    chk1("idle_ready", in_ready, 1'b1);
    chkg("idle_group", out_group, 2'd0);

    // 2: signed zero -> half the channels set
    run_window("s00", {9{8'h00}}, 1'b1, b_zero, {9{ALL1}}, {9{ALL1}}, {9{ZERO}}, {9{ZERO}});

    // 3: value corners
    run_window("s80", {9{8'h80}}, 1'b1, b_min, {9{ZERO}}, {9{ZERO}}, {9{ZERO}}, {9{ZERO}});
    run_window("s7f", {9{8'h7F}}, 1'b1, 4, {9{ALL1}}, {9{ALL1}}, {9{ALL1}},
               {9{64'h7FFF_FFFF_FFFF_FFFF}});
    run_window("u05", {9{8'h05}}, 1'b0, b_min, {9{64'h1F}}, {9{ZERO}}, {9{ZERO}}, {9{ZERO}});
    run_window("mix", {8'hC1, 48'h0, 8'h40, 8'h00}, 1'b0, 4,
               {ALL1, 384'h0, ALL1, ZERO}, {ALL1, 512'h0}, {ALL1, 512'h0},
               {64'h1, 512'h0});

    // 4: backpressure held at group 1
    in_pixel    = {9{8'h7F}};
    mode_signed = 1'b1;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("bp_valid", out_valid, 1'b1);
      chkg("bp_group", out_group, 2'd1);
      chk1("bp_last", out_last, 1'b0);
      chk1("bp_ready", in_ready, 1'b0);
      chkd("bp_data", out_data, {9{ALL1}});
    end
    out_ready = 1'b1;
    chkg("bp_resume1", out_group, 2'd1);
    step();
    chkg("bp_resume2", out_group, 2'd2);
    chkd("bp_data2", out_data, {9{ALL1}});
    step();
    chkg("bp_g3", out_group, 2'd3);
    chk1("bp_last3", out_last, 1'b1);
    chkd("bp_data3", out_data, {9{64'h7FFF_FFFF_FFFF_FFFF}});
    step();
    chk1("bp_idle", out_valid, 1'b0);

    // 5: back-to-back windows without a bubble
    in_pixel    = {9{8'hFF}};
    mode_signed = 1'b0;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    step();
    in_pixel = {9{8'hC1}};
    for (int g = 0; g < 4; g++) begin
      chk1("b2b_a_valid", out_valid, 1'b1);
      chkg("b2b_a_group", out_group, 2'(g));
      chk1("b2b_a_ready", in_ready, (g == 3));
      chkd("b2b_a_data", out_data, (g == 3) ? {9{64'h7FFF_FFFF_FFFF_FFFF}} : {9{ALL1}});
      step();
    end
    in_valid = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk1("b2b_b_valid", out_valid, 1'b1);
      chkg("b2b_b_group", out_group, 2'(g));
      chk1("b2b_b_last", out_last, (g == 3));
      chkd("b2b_b_data", out_data, (g == 3) ? {9{64'h1}} : {9{ALL1}});
      step();
    end
    chk1("b2b_idle", out_valid, 1'b0);

    // 6: asynchronous reset mid-window, then a fresh window
    in_pixel    = {9{8'h7F}};
    mode_signed = 1'b1;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chkg("ar_pre_group", out_group, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("ar_valid", out_valid, 1'b0);
    chkg("ar_group", out_group, 2'd0);
    chk1("ar_last", out_last, 1'b0);
    chkd("ar_data", out_data, 576'h0);
    chk1("ar_ready", in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    run_window("post", {9{8'h05}}, 1'b0, b_min, {9{64'h1F}}, {9{ZERO}}, {9{ZERO}}, {9{ZERO}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
